// File: rtl/connect_four_drop_ctrl_pkg.sv
// Shared constants, state encoding and width helpers for the connect-four drop controller.
package connect_four_pkg;

    localparam int DEF_COLS = 7;
    localparam int DEF_ROWS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FULL  = 2'd2
    } state_e;

    function automatic int col_w(input int cols);
        return $clog2(cols + 1);
    endfunction

    // A single-row board still needs a one-bit row field.
    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int cnt_w(input int cols, input int rows);
        return $clog2(cols * rows + 1);
    endfunction

    function automatic int height_w(input int rows);
        return $clog2(rows + 1);
    endfunction

endpackage

// File: rtl/connect_four_drop_ctrl_if.sv
// Move handshake towards the LED matrix driver: a move is transferred on any edge
// where out_valid and out_ready are both high; col/row/player hold while out_valid waits.
interface connect_four_drop_ctrl_if #(
    parameter int COLS = connect_four_pkg::DEF_COLS,
    parameter int ROWS = connect_four_pkg::DEF_ROWS
);
    import connect_four_pkg::*;

    localparam int CW = col_w(COLS);
    localparam int RW = row_w(ROWS);

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          player;

    modport master (
        output out_valid,
        output col,
        output row,
        output player,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  col,
        input  row,
        input  player,
        output out_ready
    );

endinterface

// File: rtl/connect_four_drop_ctrl_press_detector.sv
// Synchronises the column buttons and emits a single press for a one-hot vector
// that follows an all-zero vector.
module press_detector #(
    parameter int COLS        = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COLS-1:0]           pins,
    output logic                      press_valid,
    output logic [$clog2(COLS)-1:0]   press_idx
);

    localparam int IW = $clog2(COLS);

    logic [COLS-1:0] sync_q [SYNC_STAGES];
    logic [COLS-1:0] prev_q;
    logic [COLS-1:0] cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cur = sync_q[SYNC_STAGES-1];

    // Requiring an all-zero predecessor makes a held button, or a chord collapsing
    // to one bit, unable to produce a second press.
    assign press_valid = $onehot(cur) && (prev_q == '0);

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (cur[i]) begin
                press_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/connect_four_drop_ctrl.sv
// Turns column presses into validated drop moves, tracks column heights and players,
// and hands each move to the matrix driver over a valid/ready handshake.
module connect_four_drop_ctrl
    import connect_four_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COLS-1:0]            pins,
    input  logic                       new_game,
    connect_four_drop_ctrl_if.master   bus,
    output logic                       reject,
    output logic                       board_full,
    output logic [1:0]                 dbg_state
);

    localparam int CW   = col_w(COLS);
    localparam int RW   = row_w(ROWS);
    localparam int HW   = height_w(ROWS);
    localparam int CNTW = cnt_w(COLS, ROWS);
    localparam int IW   = $clog2(COLS);

    localparam logic [1:0]      ST_IDLE  = IDLE;
    localparam logic [1:0]      ST_ISSUE = ISSUE;
    localparam logic [1:0]      ST_FULL  = FULL;
    localparam logic [HW-1:0]   H_MAX    = HW'(ROWS);
    localparam logic [CNTW-1:0] TOTAL    = CNTW'(COLS * ROWS);

    logic            press_valid;
    logic [IW-1:0]   press_idx;

    logic [1:0]      state_q,  state_d;
    logic [HW-1:0]   height_q [COLS];
    logic [HW-1:0]   height_d [COLS];
    logic [CNTW-1:0] count_q,  count_d;
    logic            next_player_q, next_player_d;
    logic [CW-1:0]   col_q,    col_d;
    logic [RW-1:0]   row_q,    row_d;
    logic            player_q, player_d;
    logic            reject_q, reject_d;

    press_detector #(
        .COLS        (COLS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_press (
        .clk         (clk),
        .rst         (rst),
        .pins        (pins),
        .press_valid (press_valid),
        .press_idx   (press_idx)
    );

    always_comb begin
        state_d       = state_q;
        height_d      = height_q;
        count_d       = count_q;
        next_player_d = next_player_q;
        col_d         = col_q;
        row_d         = row_q;
        player_d      = player_q;
        reject_d      = 1'b0;

        // Clearing the board wins over a transfer or press on the same edge.
        if (new_game) begin
            for (int i = 0; i < COLS; i++) begin
                height_d[i] = '0;
            end
            count_d       = '0;
            next_player_d = 1'b0;
            state_d       = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_valid) begin
                        if (height_q[press_idx] < H_MAX) begin
                            col_d               = CW'(press_idx) + CW'(1);
                            row_d               = RW'(height_q[press_idx]);
                            player_d            = next_player_q;
                            height_d[press_idx] = height_q[press_idx] + HW'(1);
                            state_d             = ST_ISSUE;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.out_ready) begin
                        next_player_d = ~next_player_q;
                        if (count_q != TOTAL) begin
                            count_d = count_q + CNTW'(1);
                        end
                        state_d = (count_d == TOTAL) ? ST_FULL : ST_IDLE;
                    end
                end
                ST_FULL: begin
                    state_d = ST_FULL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < COLS; i++) begin
                height_q[i] <= '0;
            end
            count_q       <= '0;
            next_player_q <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            player_q      <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            height_q      <= height_d;
            count_q       <= count_d;
            next_player_q <= next_player_d;
            col_q         <= col_d;
            row_q         <= row_d;
            player_q      <= player_d;
            reject_q      <= reject_d;
        end
    end

    assign bus.out_valid = (state_q == ST_ISSUE);
    assign bus.col       = col_q;
    assign bus.row       = row_q;
    assign bus.player    = player_q;
    assign reject        = reject_q;
    assign board_full    = (state_q == ST_FULL);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_connect_four_drop_ctrl.sv
// Scoreboard bench for connect_four_drop_ctrl on the default 7x6 board.
module tb_connect_four_drop_ctrl;

  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int CW   = 3;
  localparam int RW   = 3;
  localparam int MW   = CW + RW + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] pins = '0;
  logic            new_game = 1'b0;
  logic            reject;
  logic            board_full;
  logic [1:0]      dbg_state;

  connect_four_drop_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  connect_four_drop_ctrl #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pins       (pins),
    .new_game   (new_game),
    .bus        (bus),
    .reject     (reject),
    .board_full (board_full),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int mv_seen  = 0;
  int rej_seen = 0;

  logic [MW-1:0] exp_q[$];

  int m_h[COLS];
  int m_np;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every completed transfer pops one expected move
  always @(negedge clk) begin : monitor
    logic [MW-1:0] e;
    if (!rst) begin
      if (reject) rej_seen++;
      if (bus.out_valid && bus.out_ready && !new_game) begin
        mv_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_move", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("move", {25'd0, bus.col, bus.row, bus.player}, {25'd0, e});
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) m_h[i] = 0;
    m_np  = 0;
    m_cnt = 0;
  endtask

  // Predicts a move (assuming it will be transferred) and drives one press.
  task automatic press(input int c, input int hold, input int rel);
    if (m_cnt < COLS * ROWS && m_h[c] < ROWS) begin
      exp_q.push_back({CW'(c + 1), RW'(m_h[c]), m_np[0]});
      m_h[c]++;
      m_np ^= 1;
      m_cnt++;
    end
    pins = '0;
    pins[c] = 1'b1;
    repeat (hold) tick();
    pins = '0;
    repeat (rel) tick();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, bus.out_valid}, 32'd1);
  endtask

  int rj0, mv0;

  initial begin
    bus.out_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_col",    {29'd0, bus.col}, 32'd0);
    check("rst_row",    {29'd0, bus.row}, 32'd0);
    check("rst_player", {31'd0, bus.player}, 32'd0);
    check("rst_reject", {31'd0, reject}, 32'd0);
    check("rst_full",   {31'd0, board_full}, 32'd0);
    check("rst_state",  {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) tick();

    // first move and alternation
    press(0, 4, 4);
    check("first_move_count", mv_seen, 32'd1);
    press(2, 4, 4);
    press(2, 4, 4);
    check("three_moves", mv_seen, 32'd3);

    // fill column 1, then one press too many
    for (int i = 0; i < 5; i++) press(0, 4, 4);
    rj0 = rej_seen;
    mv0 = mv_seen;
    press(0, 4, 4);
    check("reject_pulse", rej_seen - rj0, 32'd1);
    check("reject_no_move", mv_seen - mv0, 32'd0);
    check("reject_valid", {31'd0, bus.out_valid}, 32'd0);
    press(1, 4, 4);

    // chords never press; a long hold presses once
    rj0 = rej_seen;
    mv0 = mv_seen;
    pins = 7'b0000101;
    repeat (8) tick();
    pins = '0;
    repeat (4) tick();
    check("chord_no_move", mv_seen - mv0, 32'd0);
    check("chord_no_reject", rej_seen - rj0, 32'd0);
    press(3, 20, 4);
    check("hold_one_move", mv_seen - mv0, 32'd1);

    // backpressure: payload holds, a press inside the window is lost
    bus.out_ready = 1'b0;
    mv0 = mv_seen;
    exp_q.push_back({CW'(5), RW'(m_h[4]), m_np[0]});
    m_h[4]++;
    m_np ^= 1;
    m_cnt++;
    pins = '0;
    pins[4] = 1'b1;
    wait_valid("bp_valid_timeout");
    for (int i = 0; i < 8; i++) begin
      if (i == 1) pins = '0;
      if (i == 3) pins[5] = 1'b1;
      if (i == 5) pins = '0;
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_payload", {25'd0, bus.col, bus.row, bus.player}, {25'd0, exp_q[0]});
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("bp_one_move", mv_seen - mv0, 32'd1);
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // full board
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    tick();
    check("ng_full_clear", {31'd0, board_full}, 32'd0);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        press(c, 3, 3);
    repeat (2) tick();
    check("full_flag", {31'd0, board_full}, 32'd1);
    check("full_state", {30'd0, dbg_state}, 32'd2);
    rj0 = rej_seen;
    mv0 = mv_seen;
    press(0, 4, 4);
    check("full_no_reject", rej_seen - rj0, 32'd0);
    check("full_no_move", mv_seen - mv0, 32'd0);

    // new_game clears the board but keeps the last payload
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_reset();
    tick();
    check("ng_full", {31'd0, board_full}, 32'd0);
    check("ng_state", {30'd0, dbg_state}, 32'd0);
    check("ng_keep_col", {29'd0, bus.col}, 32'd7);
    check("ng_keep_row", {29'd0, bus.row}, 32'd5);
    check("ng_keep_player", {31'd0, bus.player}, 32'd1);

    // new_game beats a simultaneous transfer
    bus.out_ready = 1'b0;
    mv0 = mv_seen;
    pins = '0;
    pins[2] = 1'b1;
    wait_valid("ng_pend_timeout");
    pins = '0;
    tick();
    new_game = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    new_game = 1'b0;
    check("ng_drop_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ng_drop_state", {30'd0, dbg_state}, 32'd0);
    check("ng_drop_full", {31'd0, board_full}, 32'd0);
    repeat (3) tick();
    press(6, 4, 4);
    check("ng_after_move", mv_seen - mv0, 32'd1);

    repeat (4) tick();
    check("queue_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/connect_four_drop_ctrl.md
Name: connect_four_drop_ctrl

Overview:
- Parametrised successor to the column-select front end of the connect-four game.
- Turns raw column buttons into validated "drop" moves, tracks per-column fill height, alternates players, and rejects drops into full columns.
- Hands each accepted move to the LED matrix driver over a valid/ready handshake, and flags a full board.

Parameters:
- COLS, 7, number of columns (button pins); must be ≥2.
- ROWS, 6, discs per column; must be ≥1.
- SYNC_STAGES, 2, input synchroniser depth; must be ≥2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pins  in  COLS  column buttons, active-high, asynchronous to clk; bit i selects column i+1.
- new_game  in  1  synchronous clear of the board, level-sampled each cycle.
- out_ready  in  1  matrix driver can accept a move.
- out_valid  out  1  move on col/row/player is valid.
- col  out  CW=clog2(COLS+1)  1-based column of the last accepted move; 0 = none yet.
- row  out  RW=clog2(ROWS)  0-based landing row (0 = bottom).
- player  out  1  player of the move on col/row (0 first).
- reject  out  1  one-cycle pulse: press on a full column.
- board_full  out  1  all COLS*ROWS cells used.

Behaviour:
- Reset (async, rst=1): out_valid=0, col=0, row=0, player=0, reject=0, board_full=0; all heights=0; move count=0; next player=0; state IDLE.
- Input path: pins pass through SYNC_STAGES flops. A press is one cycle in which both hold:
  - the synchronised vector is one-hot;
  - the previous synchronised vector was all-zero.
- Multi-bit vectors never generate a press. Holding a button gives exactly one press; a new press needs a release to all-zero first.
- Latency, default settings: pins stable before rising edge E0 → press decided during the cycle after E1 → out_valid (or reject) high after E2.
- FSM states: IDLE, ISSUE, FULL.
- IDLE, press on column c with height[c] < ROWS:
  - col ← c+1, row ← height[c], player ← next player;
  - height[c] increments; go to ISSUE.
- IDLE, press on column c with height[c] == ROWS: reject=1 for one cycle; nothing else changes; stay in IDLE.
- ISSUE:
  - out_valid=1; col/row/player held stable until transfer (out_valid & out_ready on the same edge).
  - Presses in ISSUE are discarded, not queued.
  - On transfer: out_valid=0, next player toggles, move count increments; go to FULL if count == COLS*ROWS, else IDLE.
- FULL: board_full=1; every press is ignored, with no reject pulse.
- out_ready may be high before out_valid. Transfer occurs on the first edge where both are high; the minimum stay in ISSUE is one cycle.
- new_game=1 (any state), next edge:
  - heights, count and next player cleared; out_valid=0; reject=0; board_full=0; state IDLE;
  - col/row/player keep their last values.
- new_game has priority over a simultaneous transfer; that move is dropped, not counted.
- A press coincident with new_game is discarded.
- Heights saturate at ROWS and counters never wrap. The move count is sized clog2(COLS*ROWS+1).
- rst asserted mid-ISSUE immediately drops out_valid (async).

Decomposition:
- Shared package connect_four_pkg holds:
  - default COLS/ROWS constants;
  - the state enum {IDLE, ISSUE, FULL};
  - width helpers for CW, RW and the count width.
- One sub-module, press_detector (parameters COLS, SYNC_STAGES), contains the synchroniser, the one-hot check and the release-then-press edge detection.
- press_detector outputs press_valid plus a 0-based press_idx.

Test Plan:
- Reset, then pins=7'b0000001 held 3 edges, out_ready=1 → out_valid pulses 1 cycle; col=1, row=0, player=0.
- Release, then pins=7'b0000100 twice with release between, out_ready=1 → second press gives col=3, row=1, player=0, since players alternate 0,1.
- 6 drops into column 1, then a 7th press on pins bit0 → reject pulses exactly 1 cycle; out_valid stays 0; height unchanged.
- pins=7'b0000101 (two bits) → no out_valid, no reject. pins held high 20 cycles → exactly one move.
- out_ready=0 for 5 cycles after out_valid → col/row/player stable throughout; a press during that window is lost; raising out_ready completes the transfer.
- Fill all 42 cells, then a press → board_full=1 with no reject. new_game=1 together with out_ready on a pending move → state IDLE, board_full=0, next move row=0, player=0.
